ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 13 +
 rtl/ram_stream_reader_skid_fifo2.sv | 43 ++++
 rtl/ram_stream_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared widths and FSM encoding for the RAM stream reader cluster.
package ram_stream_reader_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 56;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/ram_stream_reader_skid_fifo2.sv
// Two-entry FIFO that absorbs RAM read data while the sink stalls.
module skid_fifo2 #(
  parameter int unsigned DATA_W = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Streams cmd_len consecutive words from a registered-output RAM as
// valid/ready beats, starting at cmd_base and wrapping modulo 2^ADDR_W.
module ram_stream_reader #(
  parameter int unsigned ADDR_W = ram_stream_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_stream_reader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  import ram_stream_reader_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              done_q;

  logic              accept;
  logic              issue;
  logic              pop;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [2:0]        occ_next;
  logic [DATA_W:0]   head;
  logic              head_last;
  logic              final_issue;

  assign accept      = cmd_valid && cmd_ready;
  assign pop         = out_valid && out_ready;
  assign final_issue = issue && (remaining_q == (ADDR_W + 1)'(1));

  // Occupancy the FIFO will have after this cycle's push/pop; issuing only
  // below 2 leaves room for the word that lands next cycle.
  assign occ_next = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && (cmd_len != '0)) state_d = StRun;
      StRun:   if (final_issue) state_d = StDrain;
      StDrain: if (pop && head_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    issue     = (state_q == StRun) && (occ_next < 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      last_addr_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      done_q          <= (accept && (cmd_len == '0)) || (pop && head_last);
      if (accept) begin
        addr_q      <= cmd_base;
        remaining_q <= cmd_len;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
        last_addr_q <= addr_q;
      end
    end
  end

  assign ram_addr = issue ? addr_q : last_addr_q;

  // The last-beat tag travels alongside the data through the FIFO.
  skid_fifo2 #(
    .DATA_W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, ram_dout}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign head_last = head[DATA_W];
  assign out_valid = !fifo_empty;
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = out_valid && head_last;
  assign done      = done_q;

endmodule
